disp_cmd_ctrl: RTL and testbench

Command sequencer between the FIFO-fed shared command register and the display datapath. It consumes bytes from the shared register through its has_data/rd handshake and parses them into multi-byte commands. It configures the background and foreground colour registers used by pixel generation. It writes character/attribute bytes into display memory through a write port that shares memory with the video fetch, committing a write only in cycles the video side frees.

---
 rtl/icevga_pkg.sv | 21 ++
 rtl/cmd_byte_fetch.sv | 18 +
 rtl/disp_cmd_ctrl.sv | 111 +++++++++++
 tb/tb_disp_cmd_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icevga_pkg.sv
// icevga_pkg: shared opcodes, sequencer state encodings and reset constants
package icevga_pkg;
    typedef logic [2:0] state_t;
    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_SET_BG   = 8'h01;
    localparam logic [7:0] OP_SET_FG   = 8'h02;
    localparam logic [7:0] OP_SET_ADDR = 8'h03;
    localparam logic [7:0] OP_WRITE    = 8'h04;
    localparam logic [7:0] OP_FILL     = 8'h05;
    localparam state_t IDLE     = 3'd0;
    localparam state_t ARG1     = 3'd1;
    localparam state_t ARG2     = 3'd2;
    localparam state_t WR_WAIT  = 3'd3;
    localparam state_t FILL_RUN = 3'd4;
    localparam int ADDR_MAX_DFLT = 3699;
    localparam logic [11:0] BG_RST = 12'h000;
    localparam logic [11:0] FG_RST = 12'hFFF;
    function automatic logic has_payload(input logic [7:0] op);
        return op >= OP_SET_BG && op <= OP_FILL;
    endfunction
endpackage

// File: rtl/cmd_byte_fetch.sv
// cmd_byte_fetch: one-cycle read pulse on the shared command register with an enforced gap cycle
module cmd_byte_fetch (
    input  logic       clk,
    input  logic       nrst,
    input  logic       want,
    input  logic       cmd_avail,
    input  logic [7:0] cmd_data,
    output logic       cmd_rd,
    output logic       byte_valid,
    output logic [7:0] byte_data
);
    // has_data is stale while the pop is in flight, so the pulse cycle is the gap
    assign byte_valid = want && cmd_avail && !cmd_rd;
    assign byte_data  = cmd_data;
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) cmd_rd <= 1'b0;
        else       cmd_rd <= byte_valid;
endmodule

// File: rtl/disp_cmd_ctrl.sv
// disp_cmd_ctrl: parses command bytes into colour updates and display memory writes
module disp_cmd_ctrl
    import icevga_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int ADDR_MAX = ADDR_MAX_DFLT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cmd_avail,
    input  logic [7:0]        cmd_data,
    output logic              cmd_rd,
    output logic [11:0]       bg_color,
    output logic [11:0]       fg_color,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic              mem_wr_ok,
    output logic              busy,
    output logic              cmd_err
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ADDR_MAX);
    state_t            state;
    logic [7:0]        op;
    logic [7:0]        arg1;
    logic [8:0]        fill_cnt;
    logic              want;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              commit;
    logic [ADDR_W-1:0] addr_set;
    logic [ADDR_W-1:0] addr_next;

    assign want      = (state == IDLE) || (state == ARG1) || (state == ARG2);
    assign busy      = state != IDLE;
    assign commit    = mem_we && mem_wr_ok;
    assign addr_set  = ADDR_W'({arg1, byte_data});
    assign addr_next = (mem_addr == LAST) ? '0 : mem_addr + ADDR_W'(1);

    cmd_byte_fetch u_fetch (
        .clk        (clk),
        .nrst       (nrst),
        .want       (want),
        .cmd_avail  (cmd_avail),
        .cmd_data   (cmd_data),
        .cmd_rd     (cmd_rd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            op        <= OP_NOP;
            arg1      <= 8'h00;
            fill_cnt  <= 9'd0;
            bg_color  <= BG_RST;
            fg_color  <= FG_RST;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (byte_valid) begin
                    op <= byte_data;
                    if (has_payload(byte_data)) state <= ARG1;
                    else if (byte_data != OP_NOP) cmd_err <= 1'b1;
                end
                ARG1: if (byte_valid) begin
                    arg1 <= byte_data;
                    if (op == OP_WRITE) begin
                        mem_wdata <= byte_data;
                        mem_we    <= 1'b1;
                        state     <= WR_WAIT;
                    end else begin
                        state <= ARG2;
                    end
                end
                ARG2: if (byte_valid) begin
                    state <= IDLE;
                    if (op == OP_SET_BG) bg_color <= {arg1[3:0], byte_data};
                    else if (op == OP_SET_FG) fg_color <= {arg1[3:0], byte_data};
                    else if (op == OP_SET_ADDR) begin
                        mem_addr <= (addr_set > LAST) ? '0 : addr_set;
                        if (addr_set > LAST) cmd_err <= 1'b1;
                    end else if (op == OP_FILL) begin
                        mem_wdata <= arg1;
                        fill_cnt  <= (byte_data == 8'h00) ? 9'd256 : {1'b0, byte_data};
                        mem_we    <= 1'b1;
                        state     <= FILL_RUN;
                    end
                end
                WR_WAIT: if (commit) begin
                    mem_addr <= addr_next;
                    mem_we   <= 1'b0;
                    state    <= IDLE;
                end
                FILL_RUN: if (commit) begin
                    mem_addr <= addr_next;
                    fill_cnt <= fill_cnt - 9'd1;
                    if (fill_cnt == 9'd1) begin
                        mem_we <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_cmd_ctrl.sv
// tb_disp_cmd_ctrl: table-driven command vectors plus a commit scoreboard and multi-cycle corner sequences
module tb_disp_cmd_ctrl;
    logic        clk;
    logic        nrst;
    logic        cmd_avail;
    logic [7:0]  cmd_data;
    logic        cmd_rd;
    logic [11:0] bg_color;
    logic [11:0] fg_color;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_wr_ok;
    logic        busy;
    logic        cmd_err;

    disp_cmd_ctrl dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd_avail (cmd_avail),
        .cmd_data  (cmd_data),
        .cmd_rd    (cmd_rd),
        .bg_color  (bg_color),
        .fg_color  (fg_color),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_wr_ok (mem_wr_ok),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    typedef struct {
        logic [7:0]  b0, b1, b2;
        int          n;
        logic [11:0] bg, fg, addr;
        logic        err;
    } vec_t;

    vec_t        tbl[14];
    logic [7:0]  byteq[$];
    logic [19:0] exp_q[$];
    int          ccyc[$];
    int          total = 0;
    int          bad = 0;
    int          commits = 0;
    int          cyc = 0;
    logic        ok_rand = 1'b0;
    logic        ok_val = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] inc(input logic [11:0] a);
        return (a == 12'd3699) ? 12'd0 : a + 12'd1;
    endfunction

    task automatic push_fill(input logic [11:0] a, input logic [7:0] d, input int n);
        logic [11:0] x = a;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({x, d});
            x = inc(x);
        end
    endtask

    task automatic wait_idle(input string nm, input int lim);
        int k;
        for (k = 0; k < lim; k++) begin
            @(posedge clk);
            #2;
            if (byteq.size() == 0 && !busy && !cmd_rd) break;
        end
        chk({nm, "_idle"}, (k < lim), 1);
        chk({nm, "_sb_drained"}, exp_q.size(), 0);
    endtask

    // shared-register model: pops on each read pulse, presents the head byte
    initial begin
        cmd_avail = 1'b0;
        cmd_data  = 8'h00;
        mem_wr_ok = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_rd && byteq.size() > 0) byteq.delete(0);
            cmd_avail = byteq.size() > 0;
            cmd_data  = (byteq.size() > 0) ? byteq[0] : 8'h00;
            mem_wr_ok = ok_rand ? 1'($urandom_range(0, 1)) : ok_val;
        end
    end

    initial begin
        logic prev_we, prev_rd, prev_commit;
        logic [11:0] prev_a;
        logic [7:0] prev_d;
        logic [19:0] e;
        prev_we = 0; prev_rd = 0; prev_commit = 0; prev_a = 0; prev_d = 0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                prev_we = 0; prev_rd = 0; prev_commit = 0;
            end else begin
                if (cmd_rd) begin
                    chk("rd_gap", prev_rd, 0);
                    chk("rd_while_writing", prev_we, 0);
                end
                if (mem_we && prev_we && !prev_commit) begin
                    chk("hold_addr", mem_addr, prev_a);
                    chk("hold_data", mem_wdata, prev_d);
                end
                if (mem_we && mem_wr_ok) begin
                    commits++;
                    ccyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_commit: got addr=%0h data=%0h want none", mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_addr", mem_addr, e[19:8]);
                        chk("commit_data", mem_wdata, e[7:0]);
                    end
                end
                prev_we = mem_we; prev_rd = cmd_rd; prev_commit = mem_we && mem_wr_ok;
                prev_a = mem_addr; prev_d = mem_wdata;
            end
        end
    end

    initial begin
        logic [11:0] ma;
        int hi, k, c0;
        tbl[0]  = '{8'h01, 8'h0A, 8'h5F, 3, 12'hA5F, 12'hFFF, 12'h000, 1'b0};
        tbl[1]  = '{8'h02, 8'h03, 8'hC9, 3, 12'hA5F, 12'h3C9, 12'h000, 1'b0};
        tbl[2]  = '{8'h00, 8'h00, 8'h00, 1, 12'hA5F, 12'h3C9, 12'h000, 1'b0};
        tbl[3]  = '{8'h03, 8'h00, 8'h10, 3, 12'hA5F, 12'h3C9, 12'h010, 1'b0};
        tbl[4]  = '{8'h04, 8'h41, 8'h00, 2, 12'hA5F, 12'h3C9, 12'h011, 1'b0};
        tbl[5]  = '{8'h03, 8'h0E, 8'h73, 3, 12'hA5F, 12'h3C9, 12'hE73, 1'b0};
        tbl[6]  = '{8'h04, 8'h5A, 8'h00, 2, 12'hA5F, 12'h3C9, 12'h000, 1'b0};
        tbl[7]  = '{8'h05, 8'h20, 8'h04, 3, 12'hA5F, 12'h3C9, 12'h004, 1'b0};
        tbl[8]  = '{8'h03, 8'h0E, 8'h72, 3, 12'hA5F, 12'h3C9, 12'hE72, 1'b0};
        tbl[9]  = '{8'h05, 8'h33, 8'h04, 3, 12'hA5F, 12'h3C9, 12'h002, 1'b0};
        tbl[10] = '{8'h01, 8'h00, 8'h00, 3, 12'h000, 12'h3C9, 12'h002, 1'b0};
        tbl[11] = '{8'h7E, 8'h00, 8'h00, 1, 12'h000, 12'h3C9, 12'h002, 1'b1};
        tbl[12] = '{8'h00, 8'h00, 8'h00, 1, 12'h000, 12'h3C9, 12'h002, 1'b1};
        tbl[13] = '{8'h03, 8'hFF, 8'hFF, 3, 12'h000, 12'h3C9, 12'h000, 1'b1};

        nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_rd", cmd_rd, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_bg", bg_color, 12'h000);
        chk("rst_fg", fg_color, 12'hFFF);
        chk("rst_addr", mem_addr, 12'h000);
        chk("rst_wdata", mem_wdata, 8'h00);
        nrst = 1'b1;

        ok_rand = 1'b1;
        ma = 12'h000;
        for (int i = 0; i < 14; i++) begin
            byteq.push_back(tbl[i].b0);
            if (tbl[i].n > 1) byteq.push_back(tbl[i].b1);
            if (tbl[i].n > 2) byteq.push_back(tbl[i].b2);
            if (tbl[i].b0 == 8'h04) push_fill(ma, tbl[i].b1, 1);
            if (tbl[i].b0 == 8'h05) push_fill(ma, tbl[i].b1, (tbl[i].b2 == 8'h00) ? 256 : int'(tbl[i].b2));
            wait_idle($sformatf("row%0d", i), 400);
            chk($sformatf("row%0d_bg", i), bg_color, tbl[i].bg);
            chk($sformatf("row%0d_fg", i), fg_color, tbl[i].fg);
            chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("row%0d_err", i), cmd_err, tbl[i].err);
            ma = tbl[i].addr;
        end

        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        chk("rst2_err", cmd_err, 0);

        // WRITE held across two refused slots, committed on the third
        ok_rand = 1'b0;
        ok_val  = 1'b0;
        byteq.push_back(8'h03); byteq.push_back(8'h00); byteq.push_back(8'h10);
        byteq.push_back(8'h04); byteq.push_back(8'h41);
        push_fill(12'h010, 8'h41, 1);
        c0 = commits;
        for (k = 0; k < 60; k++) begin
            @(posedge clk);
            #2;
            if (mem_we) break;
        end
        chk("wr_we_rise", mem_we, 1);
        chk("wr_addr", mem_addr, 12'h010);
        chk("wr_data", mem_wdata, 8'h41);
        hi = 1;
        @(posedge clk);
        #2;
        if (mem_we) hi++;
        ok_val = 1'b1;
        for (k = 0; k < 10; k++) begin
            @(posedge clk);
            #2;
            if (!mem_we) break;
            hi++;
        end
        chk("wr_we_cycles", hi, 3);
        wait_idle("wr", 50);
        chk("wr_commits", commits - c0, 1);
        chk("wr_addr_after", mem_addr, 12'h011);
        chk("wr_busy", busy, 0);

        // FILL across the wrap point with the slot always granted
        ccyc.delete();
        byteq.push_back(8'h03); byteq.push_back(8'h0E); byteq.push_back(8'h72);
        byteq.push_back(8'h05); byteq.push_back(8'h20); byteq.push_back(8'h04);
        push_fill(12'hE72, 8'h20, 4);
        wait_idle("wrap", 100);
        chk("wrap_commits", ccyc.size(), 4);
        if (ccyc.size() == 4) chk("wrap_b2b", ccyc[3] - ccyc[0], 3);
        chk("wrap_addr", mem_addr, 12'h002);
        chk("wrap_err", cmd_err, 0);

        // FILL count 0 with more bytes waiting the whole time
        ok_rand = 1'b1;
        c0 = commits;
        byteq.push_back(8'h05); byteq.push_back(8'h00); byteq.push_back(8'h00);
        byteq.push_back(8'h00); byteq.push_back(8'h00);
        push_fill(12'h002, 8'h00, 256);
        wait_idle("fill0", 3000);
        chk("fill0_commits", commits - c0, 256);
        chk("fill0_addr", mem_addr, 12'h102);
        chk("fill0_busy", busy, 0);

        // reset in the cycle of the 10th fill commit
        ok_rand = 1'b0;
        ok_val  = 1'b1;
        byteq.push_back(8'h01); byteq.push_back(8'h0F); byteq.push_back(8'h00);
        byteq.push_back(8'h02); byteq.push_back(8'h01); byteq.push_back(8'h23);
        byteq.push_back(8'h05); byteq.push_back(8'hAA); byteq.push_back(8'h00);
        push_fill(12'h102, 8'hAA, 256);
        c0 = commits;
        for (k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            if (commits - c0 >= 9) break;
        end
        chk("mid_commits", commits - c0, 9);
        chk("mid_bg", bg_color, 12'hF00);
        chk("mid_fg", fg_color, 12'h123);
        #1;
        nrst = 1'b0;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd", cmd_rd, 0);
        chk("mid_rst_bg", bg_color, 12'h000);
        chk("mid_rst_fg", fg_color, 12'hFFF);
        chk("mid_rst_addr", mem_addr, 12'h000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        byteq.push_back(8'h01); byteq.push_back(8'h00); byteq.push_back(8'h0F);
        wait_idle("post_rst", 50);
        chk("post_rst_bg", bg_color, 12'h00F);
        chk("post_rst_fg", fg_color, 12'hFFF);
        chk("post_rst_err", cmd_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
